// File: rtl/onchip_arb_pkg.sv
// Shared types and defaults for the two-requester on-chip RAM arbiter.
package onchip_arb_pkg;

   localparam int ADDR_W_DEF   = 10;
   localparam int DATA_W_DEF   = 32;
   localparam int LOCK_MAX_DEF = 16;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED0  = 2'd1,
      LOCKED1  = 2'd2
   } lock_state_t;

   typedef logic req_id_t;

endpackage

// File: rtl/onchip_arb_rr2.sv
// Two-way round-robin grant with its rr_ptr register; rr_ptr names the tie winner.
module onchip_arb_rr2
   import onchip_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       force_en,
   input  logic       force_ptr,
   output logic [1:0] gnt,
   output logic       rr_ptr
);

   req_id_t rr_ptr_q;

   assign rr_ptr = rr_ptr_q;

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = rr_ptr_q ? 2'b10 : 2'b01;
      end
   end

   // Any grant is an accept; the pointer moves to whichever index did not win.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= 1'b0;
      end else if (force_en) begin
         rr_ptr_q <= force_ptr;
      end else if (|gnt) begin
         rr_ptr_q <= gnt[0];
      end
   end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port RAM between two Avalon-MM requesters; optional lock FSM under ARB_LOCK_EN.
//   state    | meaning
//   UNLOCKED | plain round-robin between m0 and m1
//   LOCKED0  | only m0 may be granted until m0_lock drops or the hold limit expires
//   LOCKED1  | only m1 may be granted until m1_lock drops or the hold limit expires
module onchip_mem_arbiter
   import onchip_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int LOCK_MAX = LOCK_MAX_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic                m0_lock,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic                m1_lock,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   logic       req0, req1;
   logic [1:0] req_elig;
   logic [1:0] gnt;
   logic       rr_ptr;
   logic       rr_force;
   logic       rr_force_ptr;
   logic       rd_pend;
   req_id_t    rd_id;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

`ifdef ARB_LOCK_EN
   localparam int              CNT_W    = $clog2(LOCK_MAX);
   localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(LOCK_MAX - 2);
   localparam logic [CNT_W-1:0] TMR_ONE  = CNT_W'(1);

   lock_state_t      lock_state;
   logic [CNT_W-1:0] lock_tmr;

   always_comb begin
      req_elig = {req1, req0};
      case (lock_state)
         LOCKED0: req_elig = {1'b0, req0};
         LOCKED1: req_elig = {req1, 1'b0};
         default: req_elig = {req1, req0};
      endcase
   end

   // Hold expiry hands the next tie to the requester that was locked out.
   assign rr_force     = (lock_state != UNLOCKED) && (lock_tmr == '0);
   assign rr_force_ptr = (lock_state == LOCKED0);

   // The accept cycle counts as the first held cycle, so the timer covers LOCK_MAX-1 more.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_state <= UNLOCKED;
         lock_tmr   <= '0;
      end else begin
         case (lock_state)
            UNLOCKED: begin
               if (gnt[0] && m0_lock) begin
                  lock_state <= LOCKED0;
                  lock_tmr   <= TMR_LOAD;
               end else if (gnt[1] && m1_lock) begin
                  lock_state <= LOCKED1;
                  lock_tmr   <= TMR_LOAD;
               end
            end
            LOCKED0: begin
               if (!m0_lock || lock_tmr == '0) lock_state <= UNLOCKED;
               else                            lock_tmr   <= lock_tmr - TMR_ONE;
            end
            LOCKED1: begin
               if (!m1_lock || lock_tmr == '0) lock_state <= UNLOCKED;
               else                            lock_tmr   <= lock_tmr - TMR_ONE;
            end
            default: lock_state <= UNLOCKED;
         endcase
      end
   end
`else
   logic unused_lock;

   assign unused_lock  = m0_lock ^ m1_lock;
   assign req_elig     = {req1, req0};
   assign rr_force     = 1'b0;
   assign rr_force_ptr = 1'b0;
`endif

   onchip_arb_rr2 u_rr2 (
      .clk       (clk),
      .reset     (reset),
      .req       (req_elig),
      .force_en  (rr_force),
      .force_ptr (rr_force_ptr),
      .gnt       (gnt),
      .rr_ptr    (rr_ptr)
   );

   assign m0_waitrequest = req0 & ~gnt[0];
   assign m1_waitrequest = req1 & ~gnt[1];

   always_comb begin
      mem_address    = '0;
      mem_byteenable = '0;
      mem_write      = 1'b0;
      mem_writedata  = '0;
      if (gnt[0]) begin
         mem_address    = m0_address;
         mem_byteenable = m0_byteenable;
         mem_write      = m0_write;
         mem_writedata  = m0_writedata;
      end else if (gnt[1]) begin
         mem_address    = m1_address;
         mem_byteenable = m1_byteenable;
         mem_write      = m1_write;
         mem_writedata  = m1_writedata;
      end
   end

   assign mem_chipselect = |gnt;
   assign mem_clken      = ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend <= 1'b0;
         rd_id   <= 1'b0;
      end else begin
         rd_pend <= (gnt[0] & m0_read & ~m0_write) | (gnt[1] & m1_read & ~m1_write);
         rd_id   <= gnt[1];
      end
   end

   // Gated by reset so a read caught by reset never reports data.
   assign m0_readdatavalid = rd_pend & ~rd_id & ~reset;
   assign m1_readdatavalid = rd_pend &  rd_id & ~reset;
   assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
   assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!reset) begin
         assert (!(m0_read && m0_write))
            else $warning("m0 read and write high together; serviced as a write");
         assert (!(m1_read && m1_write))
            else $warning("m1 read and write high together; serviced as a write");
      end
   end
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 1024x32 byte-enabled RAM.
module tb_onchip_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [9:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata = 32'h0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] ram [0:1023];

   always #5 clk = ~clk;

   onchip_mem_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_lock          (m0_lock),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_lock          (m1_lock),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_clken        (mem_clken),
      .mem_readdata     (mem_readdata)
   );

   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
         else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m0_address = '0; m0_byteenable = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_lock = 0;
      m1_address = '0; m1_byteenable = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_lock = 0;
   endtask

   task automatic m0_rd(input logic [9:0] a);
      m0_address = a; m0_byteenable = 4'hF; m0_read = 1; m0_write = 0;
   endtask

   task automatic m1_rd(input logic [9:0] a);
      m1_address = a; m1_byteenable = 4'hF; m1_read = 1; m1_write = 0;
   endtask

   task automatic pulse_reset();
      idle();
      reset = 1;
      step();
      reset = 0;
   endtask

   initial begin
      idle();
      reset = 1;
      step();
      step();
      chk("rst_m0_rdv", m0_readdatavalid, 1'b0);
      chk("rst_m1_rdv", m1_readdatavalid, 1'b0);
      chk("rst_cs", mem_chipselect, 1'b0);
      chk("rst_clken", mem_clken, 1'b0);
      reset = 0;
      #1;
      chk("clken_run", mem_clken, 1'b1);
      step();

      // 1: m0 write then read back
      m0_address = 10'h005; m0_byteenable = 4'hF; m0_write = 1; m0_writedata = 32'hDEADBEEF;
      #1;
      chk("t1_wr_wait", m0_waitrequest, 1'b0);
      chk("t1_wr_memw", mem_write, 1'b1);
      chk("t1_wr_addr", mem_address, 32'h005);
      step();
      chk("t1_wr_norsp", m0_readdatavalid, 1'b0);
      idle();
      m0_rd(10'h005);
      #1;
      chk("t1_rd_wait", m0_waitrequest, 1'b0);
      chk("t1_rd_memw", mem_write, 1'b0);
      step();
      idle();
      chk("t1_rdv", m0_readdatavalid, 1'b1);
      chk("t1_data", m0_readdata, 32'hDEADBEEF);
      chk("t1_m1_rdv", m1_readdatavalid, 1'b0);
      chk("t1_m1_data", m1_readdata, 32'h0);
      step();
      chk("t1_rdv_pulse", m0_readdatavalid, 1'b0);

      // 3: m1 partial write over all-ones
      m1_address = 10'h3FF; m1_byteenable = 4'hF; m1_write = 1; m1_writedata = 32'hFFFFFFFF;
      step();
      m1_byteenable = 4'b0011; m1_writedata = 32'h12345678;
      step();
      idle();
      m1_rd(10'h3FF);
      step();
      idle();
      chk("t3_rdv", m1_readdatavalid, 1'b1);
      chk("t3_data", m1_readdata, 32'hFFFF5678);
      chk("t3_m0_rdv", m0_readdatavalid, 1'b0);

      // 2: both read continuously after reset, grants alternate from m0
      pulse_reset();
      m0_rd(10'h005);
      m1_rd(10'h3FF);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            chk("t2_m0_rdv", m0_readdatavalid, ((i - 1) % 2 == 0));
            chk("t2_m1_rdv", m1_readdatavalid, ((i - 1) % 2 == 1));
            chk("t2_data", (i % 2 == 1) ? m0_readdata : m1_readdata,
                (i % 2 == 1) ? 32'hDEADBEEF : 32'hFFFF5678);
         end
         #1;
         chk("t2_m0_wait", m0_waitrequest, (i % 2 == 1));
         chk("t2_m1_wait", m1_waitrequest, (i % 2 == 0));
         step();
      end
      idle();
      chk("t2_last_m1_rdv", m1_readdatavalid, 1'b1);
      chk("t2_last_data", m1_readdata, 32'hFFFF5678);
      step();

      // 4: reset the cycle after an accepted read; rr_ptr left at 1 before reset
      m0_rd(10'h005);
      step();
      idle();
      reset = 1;
      #1;
      chk("t4_rdv_in_rst", m0_readdatavalid, 1'b0);
      step();
      reset = 0;
      chk("t4_rdv_after", m0_readdatavalid, 1'b0);
      m0_rd(10'h005);
      m1_rd(10'h3FF);
      #1;
      chk("t4_tie_m0", m0_waitrequest, 1'b0);
      chk("t4_tie_m1", m1_waitrequest, 1'b1);
      step();
      idle();
      chk("t4_m0_rdv", m0_readdatavalid, 1'b1);
      step();

      // 6: read and write together behaves as a write
      m0_address = 10'h010; m0_byteenable = 4'hF; m0_read = 1; m0_write = 1;
      m0_writedata = 32'hA5A5A5A5;
      #1;
      chk("t6_memw", mem_write, 1'b1);
      step();
      idle();
      chk("t6_no_rdv", m0_readdatavalid, 1'b0);
      m0_rd(10'h010);
      step();
      idle();
      chk("t6_readback", m0_readdata, 32'hA5A5A5A5);
      step();

`ifdef ARB_LOCK_EN
      // 5a: lock held past LOCK_MAX; m1 waits 16 cycles then wins
      pulse_reset();
      m0_rd(10'h005); m0_lock = 1;
      m1_rd(10'h3FF);
      for (int i = 0; i < 17; i++) begin
         #1;
         chk("t5_m0_wait", m0_waitrequest, (i == 16));
         chk("t5_m1_wait", m1_waitrequest, (i < 16));
         step();
      end
      // 5b: lock released after 3 cycles
      pulse_reset();
      m0_rd(10'h005); m0_lock = 1;
      m1_rd(10'h3FF);
      for (int i = 0; i < 5; i++) begin
         if (i == 3) m0_lock = 0;
         #1;
         chk("t5b_m1_wait", m1_waitrequest, (i < 4));
         step();
      end
      idle();
`else
      // lock inputs have no effect without the lock feature
      pulse_reset();
      m0_rd(10'h005); m0_lock = 1;
      step();
      m1_rd(10'h3FF); m1_lock = 0;
      #1;
      chk("nolock_m1_win", m1_waitrequest, 1'b0);
      chk("nolock_m0_wait", m0_waitrequest, 1'b1);
      step();
      idle();
`endif

      // idle cycle: no RAM access
      #1;
      chk("idle_cs", mem_chipselect, 1'b0);
      chk("idle_addr", mem_address, 32'h0);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
